// File: rtl/cmd_pkg.sv
// Shared types for the drive-command framer: parser states, command record, default sync byte.
package cmd_pkg;

  typedef enum logic [2:0] {HUNT, LMOT, RMOT, DUR, CSUM, HOLD} parse_state_t;

  typedef struct packed {
    logic [7:0] lmotor;
    logic [7:0] rmotor;
    logic [7:0] dur;
  } drive_cmd_t;

  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  function automatic logic [7:0] cmd_csum(input drive_cmd_t c);
    return c.lmotor ^ c.rmotor ^ c.dur;
  endfunction

endpackage

// File: rtl/cmd_frame_parser_byte_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags the cycle the limit is hit.
module byte_timeout #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] count;

  // A byte arriving in the limit cycle suppresses expiry.
  assign expired = enable && !clear && (count == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || !enable || expired) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/cmd_frame_parser.sv
// Frames the UART RX byte stream into validated {lmotor,rmotor,dur} drive commands.
// Define CMD_CHECKSUM_EN for the 5-byte frame with a trailing XOR checksum byte.
module cmd_frame_parser
  import cmd_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  parameter int         TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [7:0] lmotor,
  output logic [7:0] rmotor,
  output logic [7:0] dur,
  output logic       frame_err,
  output logic [7:0] err_count
);

  parse_state_t state;
  drive_cmd_t   shadow, shadow_next, cmd_q;
  logic         in_frame, expired, err_now, is_sync;

  assign in_frame = (state == LMOT) || (state == RMOT) || (state == DUR) || (state == CSUM);
  assign is_sync  = rx_valid && (rx_byte == SYNC_BYTE);

  byte_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (rx_valid),
    .enable  (in_frame),
    .expired (expired)
  );

  // NOTE: every variable gets a default before the case so no path infers a latch.
  always_comb begin
    shadow_next = shadow;
    if (rx_valid) begin
      case (state)
        LMOT:    shadow_next.lmotor = rx_byte;
        RMOT:    shadow_next.rmotor = rx_byte;
        DUR:     shadow_next.dur    = rx_byte;
        default: ;
      endcase
    end
  end

  always_comb begin
    err_now = expired;
    if (state == HOLD && rx_valid && !cmd_ready) err_now = 1'b1;
`ifdef CMD_CHECKSUM_EN
    if (state == CSUM && rx_valid && rx_byte != cmd_csum(shadow)) err_now = 1'b1;
`endif
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= HUNT;
      shadow    <= '0;
      cmd_q     <= '0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      err_count <= 8'h00;
    end else begin
      frame_err <= err_now;
      if (err_now && err_count != 8'hFF) err_count <= err_count + 8'd1;
      shadow <= shadow_next;

      case (state)
        HUNT: if (is_sync) state <= LMOT;
        LMOT: begin
          if (rx_valid)     state <= RMOT;
          else if (expired) state <= HUNT;
        end
        RMOT: begin
          if (rx_valid)     state <= DUR;
          else if (expired) state <= HUNT;
        end
        DUR: begin
          if (rx_valid) begin
`ifdef CMD_CHECKSUM_EN
            state <= CSUM;
`else
            state     <= HOLD;
            cmd_valid <= 1'b1;
            cmd_q     <= shadow_next;
`endif
          end else if (expired) begin
            state <= HUNT;
          end
        end
`ifdef CMD_CHECKSUM_EN
        CSUM: begin
          if (rx_valid) begin
            if (rx_byte == cmd_csum(shadow)) begin
              state     <= HOLD;
              cmd_valid <= 1'b1;
              cmd_q     <= shadow;
            end else begin
              state <= HUNT;
            end
          end else if (expired) begin
            state <= HUNT;
          end
        end
`endif
        HOLD: begin
          // A sync byte landing on the handshake cycle starts the next frame directly.
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= is_sync ? LMOT : HUNT;
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

  assign lmotor = cmd_q.lmotor;
  assign rmotor = cmd_q.rmotor;
  assign dur    = cmd_q.dur;

endmodule
